// File: rtl/race_controller_if.sv
// Bundles the start/pause buttons, car positions and game-status outputs
// that pass between the racer top level and the race sequencer.
interface race_controller_if;
  logic        start;
  logic        pause;
  logic [9:0]  p1_x;
  logic [9:0]  p1_y;
  logic [9:0]  p2_x;
  logic [9:0]  p2_y;
  logic [2:0]  state;
  logic        engine_rst;
  logic [2:0]  count_digit;
  logic [2:0]  lap_p1;
  logic [2:0]  lap_p2;
  logic [1:0]  winner;
  logic [15:0] race_frames;

  // Game top level: drives buttons and positions, watches game status.
  modport master (
    output start, pause, p1_x, p1_y, p2_x, p2_y,
    input  state, engine_rst, count_digit, lap_p1, lap_p2, winner, race_frames
  );

  // Sequencer side.
  modport slave (
    input  start, pause, p1_x, p1_y, p2_x, p2_y,
    output state, engine_rst, count_digit, lap_p1, lap_p2, winner, race_frames
  );
endinterface

// File: rtl/race_controller.sv
// Two-car race sequencer: countdown, lap counting from finish/checkpoint
// zones, winner detection and race timing in 60 Hz frames.
module race_controller #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int LAPS        = 3,
  parameter int COUNTDOWN_S = 3,
  parameter int FIN_X0      = 150,
  parameter int FIN_X1      = 170,
  parameter int FIN_Y0      = 10,
  parameter int FIN_Y1      = 60,
  parameter int CP_X0       = 150,
  parameter int CP_X1       = 170,
  parameter int CP_Y0       = 180,
  parameter int CP_Y1       = 230
) (
  input  logic              clk,
  input  logic              rst_n,
  race_controller_if.slave  bus
);

  localparam int TICK_DIV = CLK_FREQ / 60;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  localparam logic [2:0] LAPS_C  = 3'(LAPS);
  localparam logic [2:0] COUNT_C = 3'(COUNTDOWN_S);

  localparam logic [9:0] FX0 = 10'(FIN_X0);
  localparam logic [9:0] FX1 = 10'(FIN_X1);
  localparam logic [9:0] FY0 = 10'(FIN_Y0);
  localparam logic [9:0] FY1 = 10'(FIN_Y1);
  localparam logic [9:0] CX0 = 10'(CP_X0);
  localparam logic [9:0] CX1 = 10'(CP_X1);
  localparam logic [9:0] CY0 = 10'(CP_Y0);
  localparam logic [9:0] CY1 = 10'(CP_Y1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd3,
    S_RACE   = 3'd4,
    S_PAUSE  = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic              engine_rst_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [5:0]        frame_q, frame_d;
  logic [2:0]        count_q, count_d;
  logic [2:0]        lap1_q, lap1_d;
  logic [2:0]        lap2_q, lap2_d;
  logic              arm1_q, arm1_d;
  logic              arm2_q, arm2_d;
  logic [1:0]        winner_q, winner_d;
  logic [15:0]       race_frames_q, race_frames_d;

  logic game_tick;
  logic in_fin1, in_fin2, in_cp1, in_cp2;
  logic win1, win2;

  assign game_tick = (tick_cnt_q == '0);

  // Zone membership, inclusive unsigned rectangle compares.
  assign in_fin1 = (bus.p1_x >= FX0) && (bus.p1_x <= FX1) && (bus.p1_y >= FY0) && (bus.p1_y <= FY1);
  assign in_fin2 = (bus.p2_x >= FX0) && (bus.p2_x <= FX1) && (bus.p2_y >= FY0) && (bus.p2_y <= FY1);
  assign in_cp1  = (bus.p1_x >= CX0) && (bus.p1_x <= CX1) && (bus.p1_y >= CY0) && (bus.p1_y <= CY1);
  assign in_cp2  = (bus.p2_x >= CX0) && (bus.p2_x <= CX1) && (bus.p2_y >= CY0) && (bus.p2_y <= CY1);

  assign win1 = (lap1_d == LAPS_C);
  assign win2 = (lap2_d == LAPS_C);

  // 60 Hz tick divider; realigned on start so the first countdown tick is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      tick_cnt_q <= TICK_W'(1);
    end else if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end
  end

  // Game state and all game counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      engine_rst_q  <= 1'b1;
      frame_q       <= '0;
      count_q       <= '0;
      lap1_q        <= '0;
      lap2_q        <= '0;
      arm1_q        <= 1'b0;
      arm2_q        <= 1'b0;
      winner_q      <= '0;
      race_frames_q <= '0;
    end else begin
      state_q       <= state_d;
      engine_rst_q  <= (state_q == S_IDLE);
      frame_q       <= frame_d;
      count_q       <= count_d;
      lap1_q        <= lap1_d;
      lap2_q        <= lap2_d;
      arm1_q        <= arm1_d;
      arm2_q        <= arm2_d;
      winner_q      <= winner_d;
      race_frames_q <= race_frames_d;
    end
  end

  // Next-state and counter update rules for every game phase.
  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    count_d       = count_q;
    lap1_d        = lap1_q;
    lap2_d        = lap2_q;
    arm1_d        = arm1_q;
    arm2_d        = arm2_q;
    winner_d      = winner_q;
    race_frames_d = race_frames_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_COUNT;
          count_d       = COUNT_C;
          frame_d       = '0;
          lap1_d        = '0;
          lap2_d        = '0;
          arm1_d        = 1'b0;
          arm2_d        = 1'b0;
          winner_d      = '0;
          race_frames_d = '0;
        end
      end

      S_COUNT: begin
        if (game_tick) begin
          if (frame_q == 6'd59) begin
            frame_d = '0;
            count_d = count_q - 3'd1;
            if (count_q == 3'd1) begin
              state_d = S_RACE;
            end
          end else begin
            frame_d = frame_q + 6'd1;
          end
        end
      end

      S_RACE: begin
        if (bus.pause) begin
          state_d = S_PAUSE;
        end
        if (game_tick) begin
          if (race_frames_q != 16'hFFFF) begin
            race_frames_d = race_frames_q + 16'd1;
          end
          // Arming and counting both look at the pre-tick armed flag.
          if (in_cp1) begin
            arm1_d = 1'b1;
          end
          if (in_fin1 && arm1_q && (lap1_q != LAPS_C)) begin
            lap1_d = lap1_q + 3'd1;
            arm1_d = 1'b0;
          end
          if (in_cp2) begin
            arm2_d = 1'b1;
          end
          if (in_fin2 && arm2_q && (lap2_q != LAPS_C)) begin
            lap2_d = lap2_q + 3'd1;
            arm2_d = 1'b0;
          end
          // A finished race overrides a coincident pause.
          if (win1 || win2) begin
            winner_d = {win2, win1};
            state_d  = S_FINISH;
          end
        end
      end

      S_PAUSE: begin
        if (bus.start) begin
          state_d = S_IDLE;
        end else if (bus.pause) begin
          state_d = S_RACE;
        end
      end

      S_FINISH: begin
        if (bus.start) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign bus.state       = state_q;
  assign bus.engine_rst  = engine_rst_q;
  assign bus.count_digit = count_q;
  assign bus.lap_p1      = lap1_q;
  assign bus.lap_p2      = lap2_q;
  assign bus.winner      = winner_q;
  assign bus.race_frames = race_frames_q;

endmodule

// File: tb/tb_race_controller.sv
// Bench for race_controller: a behavioural game model checked every cycle
// against instance A (3 laps), plus directed literal checks on A and on a
// one-lap instance B for the simultaneous-finish case.
module tb_race_controller;
  localparam int CF  = 600;
  localparam int DIV = CF / 60;
  localparam int CDS = 3;
  localparam int LAPS_A = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  race_controller_if ia();
  race_controller_if ib();

  race_controller #(.CLK_FREQ(CF), .LAPS(LAPS_A), .COUNTDOWN_S(CDS)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );
  race_controller #(.CLK_FREQ(CF), .LAPS(1), .COUNTDOWN_S(CDS)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of instance A ----------------
  int m_state, m_rst, m_digit, m_cd_ticks, m_win, m_frames, m_phase;
  int m_lap[2];
  int m_arm[2];

  function automatic bit in_rect(input int x, input int y, input int x0, input int x1,
                                 input int y0, input int y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  task automatic m_reset();
    m_state = 0; m_rst = 1; m_digit = 0; m_cd_ticks = 0; m_win = 0;
    m_frames = 0; m_phase = 0;
    m_lap[0] = 0; m_lap[1] = 0; m_arm[0] = 0; m_arm[1] = 0;
  endtask

  task automatic m_step();
    bit tick;
    int old, w;
    int px[2];
    int py[2];
    px[0] = int'(ia.p1_x); py[0] = int'(ia.p1_y);
    px[1] = int'(ia.p2_x); py[1] = int'(ia.p2_y);
    tick = (m_phase == 0);
    old = m_state;
    m_phase = (old == 0 && ia.start) ? 1 : (m_phase + 1) % DIV;
    m_rst = (old == 0) ? 1 : 0;
    case (old)
      0: if (ia.start) begin
        m_state = 3; m_digit = CDS; m_cd_ticks = 0; m_win = 0; m_frames = 0;
        m_lap[0] = 0; m_lap[1] = 0; m_arm[0] = 0; m_arm[1] = 0;
      end
      3: if (tick) begin
        m_cd_ticks++;
        m_digit = CDS - m_cd_ticks / 60;
        if (m_digit == 0) m_state = 4;
      end
      4: begin
        if (ia.pause) m_state = 5;
        if (tick) begin
          m_frames = (m_frames < 65535) ? m_frames + 1 : 65535;
          for (int c = 0; c < 2; c++) begin
            int was_armed;
            was_armed = m_arm[c];
            if (in_rect(px[c], py[c], 150, 170, 180, 230)) m_arm[c] = 1;
            if (in_rect(px[c], py[c], 150, 170, 10, 60) && was_armed == 1 && m_lap[c] < LAPS_A) begin
              m_lap[c]++;
              m_arm[c] = 0;
            end
          end
          w = 0;
          if (m_lap[0] == LAPS_A) w += 1;
          if (m_lap[1] == LAPS_A) w += 2;
          if (w != 0) begin
            m_win = w;
            m_state = 6;
          end
        end
      end
      5: if (ia.start) m_state = 0; else if (ia.pause) m_state = 4;
      6: if (ia.start) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison of instance A against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("a_state", ia.state, m_state);
      chk("a_engine_rst", ia.engine_rst, m_rst);
      chk("a_count_digit", ia.count_digit, m_digit);
      chk("a_lap_p1", ia.lap_p1, m_lap[0]);
      chk("a_lap_p2", ia.lap_p2, m_lap[1]);
      chk("a_winner", ia.winner, m_win);
      chk("a_race_frames", ia.race_frames, m_frames);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit on_b, input bit is_pause);
    @(negedge clk);
    if (on_b) begin
      if (is_pause) ib.pause = 1'b1; else ib.start = 1'b1;
    end else begin
      if (is_pause) ia.pause = 1'b1; else ia.start = 1'b1;
    end
    $display("[%0t] %s pulse on instance %s", $time, is_pause ? "pause" : "start", on_b ? "B" : "A");
    @(negedge clk);
    ia.start = 1'b0; ia.pause = 1'b0; ib.start = 1'b0; ib.pause = 1'b0;
  endtask

  task automatic car1_a(input int x, input int y, input int hold);
    ia.p1_x = 10'(x); ia.p1_y = 10'(y);
    $display("[%0t] A car1 -> (%0d,%0d) for %0d clk", $time, x, y, hold);
    wait_cyc(hold);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time %0t, want finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    ia.start = 0; ia.pause = 0; ia.p1_x = 0; ia.p1_y = 0; ia.p2_x = 0; ia.p2_y = 0;
    ib.start = 0; ib.pause = 0; ib.p1_x = 0; ib.p1_y = 0; ib.p2_x = 0; ib.p2_y = 0;
    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", ia.state, 0);
    chk("rst_engine_rst", ia.engine_rst, 1);
    chk("rst_frames", ia.race_frames, 0);
    chk("rst_winner", ia.winner, 0);

    // pause ignored in IDLE
    pulse(0, 1);
    chk("idle_pause_ignored", ia.state, 0);

    // Countdown: start accepted at edge E0; now just after E0.
    pulse(0, 0);
    chk("cd_state", ia.state, 3);
    chk("cd_digit3", ia.count_digit, 3);
    wait_cyc(1);
    chk("cd_engine_rst_low", ia.engine_rst, 0);
    wait_cyc(598);
    chk("cd_digit3_end", ia.count_digit, 3);
    wait_cyc(1);
    chk("cd_digit2", ia.count_digit, 2);
    wait_cyc(600);
    chk("cd_digit1", ia.count_digit, 1);
    wait_cyc(599);
    chk("cd_state_1799", ia.state, 3);
    wait_cyc(1);
    chk("race_at_1800", ia.state, 4);
    chk("race_digit0", ia.count_digit, 0);

    // Laps for car 1
    car1_a(160, 30, 20);
    chk("fin_without_cp", ia.lap_p1, 0);
    car1_a(0, 0, 20);
    car1_a(160, 200, 20);
    car1_a(0, 0, 20);
    car1_a(160, 30, 20);
    chk("lap1_first", ia.lap_p1, 1);
    car1_a(0, 0, 20);
    car1_a(160, 30, 20);
    chk("lap1_refin_nocount", ia.lap_p1, 1);
    car1_a(0, 0, 20);
    car1_a(160, 200, 20);
    car1_a(0, 0, 20);
    car1_a(160, 30, 20);
    car1_a(0, 0, 20);
    chk("lap1_two", ia.lap_p1, 2);
    chk("lap2_zero", ia.lap_p2, 0);

    // Pause at race_frames = 100
    for (int i = 0; i < 2000 && ia.race_frames != 16'd100; i++) @(negedge clk);
    chk("reach_frames100", ia.race_frames, 100);
    pulse(0, 1);
    wait_cyc(500);
    chk("paused_state", ia.state, 5);
    chk("paused_frames", ia.race_frames, 100);
    pulse(0, 1);
    wait_cyc(30);
    chk("resumed_state", ia.state, 4);
    chk("resumed_frames_grow", (ia.race_frames > 16'd100) ? 1 : 0, 1);
    pulse(0, 1);
    pulse(0, 0);
    chk("abort_state", ia.state, 0);
    wait_cyc(1);
    chk("abort_engine_rst", ia.engine_rst, 1);
    chk("idle_laps_kept", ia.lap_p1, 2);

    // New race, saturation
    pulse(0, 0);
    chk("restart_laps_cleared", ia.lap_p1, 0);
    wait_cyc(1800);
    chk("race2_state", ia.state, 4);
    @(posedge clk);
    #2;
    force dut_a.race_frames_q = 16'hFFFE;
    m_frames = 16'hFFFE;
    $display("[%0t] A race_frames preset to 0xFFFE", $time);
    #1;
    release dut_a.race_frames_q;
    wait_cyc(35);
    chk("frames_saturate", ia.race_frames, 16'hFFFF);

    // Async reset mid-countdown
    pulse(0, 1);
    pulse(0, 0);
    pulse(0, 0);
    wait_cyc(300);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    $display("[%0t] rst_n asserted mid-countdown", $time);
    #1;
    chk("async_rst_state", ia.state, 0);
    chk("async_rst_digit", ia.count_digit, 0);
    chk("async_rst_engine", ia.engine_rst, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    $display("[%0t] rst_n released", $time);
    wait_cyc(50);
    chk("post_rst_idle", ia.state, 0);
    pulse(0, 0);
    chk("post_rst_start", ia.state, 3);

    // Instance B: one lap, simultaneous finish
    pulse(1, 0);
    wait_cyc(1800);
    chk("b_race", ib.state, 4);
    ib.p1_x = 160; ib.p1_y = 200; ib.p2_x = 165; ib.p2_y = 220;
    $display("[%0t] B both cars -> checkpoint", $time);
    wait_cyc(20);
    chk("b_no_winner_yet", ib.winner, 0);
    ib.p1_x = 160; ib.p1_y = 30; ib.p2_x = 170; ib.p2_y = 60;
    $display("[%0t] B both cars -> finish", $time);
    for (int i = 0; i < 30 && ib.winner == 2'd0; i++) @(negedge clk);
    chk("b_winner_tie", ib.winner, 3);
    chk("b_lap_p1", ib.lap_p1, 1);
    chk("b_lap_p2", ib.lap_p2, 1);
    chk("b_finish_state", ib.state, 6);
    wait_cyc(20);
    chk("b_finish_hold", ib.state, 6);
    chk("b_frames_hold_lap", ib.lap_p1, 1);
    pulse(1, 0);
    chk("b_to_idle", ib.state, 0);
    chk("b_winner_kept_idle", ib.winner, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
Top-level game sequencer for the two-car racer. It generates the shared 3-bit game `state` that gates both PhysicsEngine instances (engines move only in state 4), and it holds the engines in reset between races. It runs the start countdown, counts laps for each car from its position outputs, detects the winner, and times the race in 60 Hz frames.

Parameters:
- CLK_FREQ, 100_000_000: clock frequency in Hz. Tick period is CLK_FREQ/60 cycles.
- LAPS, 3: laps to win, range 1..7.
- COUNTDOWN_S, 3: countdown length in seconds, range 1..7.
- FIN_X0, FIN_X1, FIN_Y0, FIN_Y1 (defaults 150, 170, 10, 60): finish-zone rectangle, inclusive, in map pixels.
- CP_X0, CP_X1, CP_Y0, CP_Y1 (defaults 150, 170, 180, 230): checkpoint-zone rectangle, inclusive.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse from the debounced start button
- pause  in  1  one-cycle pulse from the debounced pause button
- p1_x, p1_y  in  10 each  car 1 pos_x/pos_y from its PhysicsEngine
- p2_x, p2_y  in  10 each  car 2 position
- state  out  3  game state: 0 IDLE, 3 COUNTDOWN, 4 RACE, 5 PAUSE, 6 FINISH
- engine_rst  out  1  active-high reset to both PhysicsEngines
- count_digit  out  3  countdown seconds remaining; 0 outside COUNTDOWN
- lap_p1, lap_p2  out  3 each  completed laps
- winner  out  2  0 none, 1 car 1, 2 car 2, 3 tie
- race_frames  out  16  60 Hz frames spent in RACE, saturating

Behaviour:
- Reset is asynchronous on rst_n low. All outputs are registered. Reset values:
  - state = 0, engine_rst = 1
  - count_digit, lap_p1, lap_p2, winner, race_frames = 0
  - armed flags = 0, tick counter = 0
- Tick:
  - Counter runs 0..CLK_FREQ/60-1; game_tick is high when the counter is 0.
  - The counter is forced to 1 on the cycle that accepts start in IDLE, so the first countdown tick lands exactly CLK_FREQ/60 cycles later.
- engine_rst = 1 whenever state is IDLE, registered. It therefore deasserts one cycle after the IDLE to COUNTDOWN transition.
- IDLE:
  - start moves to COUNTDOWN.
  - Same cycle: count_digit <= COUNTDOWN_S; frame counter = 0; laps, winner, race_frames and armed flags cleared.
  - pause is ignored.
- COUNTDOWN:
  - A frame counter counts game_ticks. On every 60th tick count_digit decrements.
  - On the tick where count_digit goes 1 to 0, move to RACE.
  - start and pause are ignored.
- RACE, on each game_tick:
  - race_frames += 1, saturating at 0xFFFF.
  - Per car: armed <= 1 when the position is inside the CP rectangle.
  - If the position is inside the FIN rectangle and armed = 1, then lap += 1 and armed <= 0.
  - Zone tests are unsigned inclusive compares. The armed-set and the lap-count are evaluated from the pre-tick armed value, so one tick cannot both arm and count.
  - If after the update lap_p1 == LAPS or lap_p2 == LAPS:
    - winner = 1 for car 1 only, 2 for car 2 only, 3 for both on the same tick.
    - state goes to FINISH on the next cycle.
  - Lap counters never exceed LAPS.
- RACE to PAUSE on a pause pulse, any cycle. PAUSE to RACE on a pause pulse. In PAUSE, race_frames, laps and armed flags are frozen.
- PAUSE + start: go to IDLE (abort). start has priority over a simultaneous pause.
- FINISH:
  - All counters, winner and laps are held.
  - start goes to IDLE. Laps and winner are cleared on the next start from IDLE, not on entry to IDLE.
- start is ignored in RACE. A pause pulse and a lap completion in the same cycle: the lap update takes effect before PAUSE is entered.
- Illegal state encodings go to IDLE.

Test Plan:
- CLK_FREQ=600 (tick every 10 clk), COUNTDOWN_S=3. Pulse start in IDLE:
  - count_digit reads 3, 2, 1 across the countdown; state = 4 exactly 1800 clk after the start pulse.
  - engine_rst = 0 from 1 cycle after the start pulse.
- In RACE, drive car 1 CP → FIN → FIN → CP → FIN:
  - lap_p1 = 2; the second FIN visit does not count.
  - Car 1 directly into FIN without a CP visit: lap_p1 stays 0.
- LAPS=1. Both cars complete their lap on the same tick → winner = 3, state = 6 the cycle after.
- Pause pulse in RACE at race_frames=100, hold 500 clk, pause again:
  - race_frames stays 100 while paused, then resumes incrementing.
  - start pulse while paused → state 0, engine_rst = 1.
- Assert rst_n low mid-COUNTDOWN, asynchronously between clock edges:
  - state = 0, count_digit = 0, engine_rst = 1 immediately.
  - After release, start is required to begin again.
- Force race_frames to 0xFFFE, run 3 ticks → race_frames holds at 0xFFFF.
